// File: rtl/pe_config_loader_if.sv
// pe_config_loader_if: host instruction stream (valid/ready) feeding the
// PE configuration loader. The host drives through "master"; the loader
// receives through "slave".
interface pe_config_loader_if #(
    parameter int PE_INST_W = 28
);
    logic [PE_INST_W-1:0] s_inst_data;
    logic                 s_inst_valid;
    logic                 s_inst_ready;

    modport master (
        output s_inst_data,
        output s_inst_valid,
        input  s_inst_ready
    );

    modport slave (
        input  s_inst_data,
        input  s_inst_valid,
        output s_inst_ready
    );
endinterface

// File: rtl/pe_config_loader.sv
// pe_config_loader: transmit side of the PE configuration interface.
// For each accepted start it resets the PE for one cycle, streams inst_len
// host words into the PE buffer with init, then holds run high for run_len
// cycles and pulses done. The PE's own counters only clear on reset, which
// is why every load is preceded by a pe_rst pulse.
// Optional feature: define LOADER_ABORT_EN to add an abort input that
// cancels a sequence in CLR/LOAD/RUN (pe_rst + err pulse, back to IDLE).
module pe_config_loader #(
    parameter int PE_INST_W = 28,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef LOADER_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [CNT_W-1:0]     inst_len,
    input  logic [CNT_W-1:0]     run_len,
    pe_config_loader_if.slave    inst,
    output logic                 pe_rst,
    output logic [PE_INST_W-1:0] PE_inst,
    output logic                 init,
    output logic                 run,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        RUN,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t               state;
    state_t               state_d;
    logic [CNT_W-1:0]     inst_len_q;
    logic [CNT_W-1:0]     inst_len_d;
    logic [CNT_W-1:0]     run_len_q;
    logic [CNT_W-1:0]     run_len_d;
    logic [CNT_W-1:0]     load_cnt;
    logic [CNT_W-1:0]     load_cnt_d;
    logic [CNT_W-1:0]     load_cnt_inc;
    logic [CNT_W-1:0]     run_cnt;
    logic [CNT_W-1:0]     run_cnt_d;
    logic [CNT_W-1:0]     run_cnt_inc;
    logic [PE_INST_W-1:0] word_d;
    logic                 init_d;
    logic                 run_d;
    logic                 done_d;
    logic                 err_d;
    logic                 pe_rst_d;
    logic                 busy_d;
    logic                 len_ok;
    logic                 hs;

    // A request is legal when 1 <= inst_len <= DEPTH and 1 <= run_len <= inst_len.
    assign len_ok = (inst_len != '0) && (inst_len <= DEPTH_C) &&
                    (run_len != '0) && (run_len <= inst_len);

    // Ready is the only combinational output: asserted for the whole of LOAD.
    assign inst.s_inst_ready = (state == LOAD);
    assign hs                = inst.s_inst_valid && inst.s_inst_ready;
    assign load_cnt_inc      = load_cnt + ONE_C;
    assign run_cnt_inc       = run_cnt + ONE_C;

    // Next-state and next-output decode; all PE strobes are registered from here.
    always_comb begin
        state_d    = state;
        inst_len_d = inst_len_q;
        run_len_d  = run_len_q;
        load_cnt_d = load_cnt;
        run_cnt_d  = run_cnt;
        word_d     = PE_inst;
        init_d     = 1'b0;
        run_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pe_rst_d   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        inst_len_d = inst_len;
                        run_len_d  = run_len;
                        pe_rst_d   = 1'b1;
                        state_d    = CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLR: begin
                load_cnt_d = '0;
                state_d    = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    word_d     = inst.s_inst_data;
                    init_d     = 1'b1;
                    load_cnt_d = load_cnt_inc;
                    // Entering RUN on the last handshake lets the first run
                    // strobe follow the last init with no gap cycle.
                    if (load_cnt_inc == inst_len_q) begin
                        run_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                run_d     = 1'b1;
                run_cnt_d = run_cnt_inc;
                if (run_cnt_inc == run_len_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LOADER_ABORT_EN
        // Abort overrides whatever the active state decided this cycle.
        if (abort && (state inside {CLR, LOAD, RUN})) begin
            state_d  = IDLE;
            word_d   = PE_inst;
            init_d   = 1'b0;
            run_d    = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            pe_rst_d = 1'b1;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // State, latched lengths and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            inst_len_q <= '0;
            run_len_q  <= '0;
            load_cnt   <= '0;
            run_cnt    <= '0;
        end else begin
            state      <= state_d;
            inst_len_q <= inst_len_d;
            run_len_q  <= run_len_d;
            load_cnt   <= load_cnt_d;
            run_cnt    <= run_cnt_d;
        end
    end

    // Registered PE-facing outputs; pe_rst is held high while the loader is in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PE_inst <= '0;
            init    <= 1'b0;
            run     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            pe_rst  <= 1'b1;
        end else begin
            PE_inst <= word_d;
            init    <= init_d;
            run     <= run_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            pe_rst  <= pe_rst_d;
        end
    end

    // The PE must never see a buffer write and an execute in the same cycle.
    assert property (@(posedge clk) disable iff (!rst) !(init && run));

    // done and err report different outcomes and never coincide.
    assert property (@(posedge clk) disable iff (!rst) !(done && err));

endmodule

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader: randomized bench for pe_config_loader. A timeline
// model predicts, per cycle after a start, the expected PE strobes and the
// word on PE_inst from the host valid pattern alone.
`timescale 1ns/1ps
module tb_pe_config_loader;

    localparam int PE_INST_W = 28;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 5;
    localparam int MAXC      = 128;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [CNT_W-1:0]     inst_len = '0;
    logic [CNT_W-1:0]     run_len = '0;
    logic                 pe_rst;
    logic [PE_INST_W-1:0] PE_inst;
    logic                 init;
    logic                 run;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef LOADER_ABORT_EN
    logic                 abort = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus pattern indexed by cycle relative to the start cycle.
    bit                   vpat [MAXC];
    logic [PE_INST_W-1:0] dpat [MAXC];
    bit                   spat [MAXC];

    // Expected per-cycle observations.
    bit                   e_prst [MAXC];
    bit                   e_init [MAXC];
    bit                   e_run  [MAXC];
    bit                   e_busy [MAXC];
    bit                   e_done [MAXC];
    bit                   e_err  [MAXC];
    bit                   e_rdy  [MAXC];
    logic [PE_INST_W-1:0] e_word [MAXC];
    logic [PE_INST_W-1:0] last_word = '0;

    pe_config_loader_if #(.PE_INST_W(PE_INST_W)) host ();

    pe_config_loader #(
        .PE_INST_W (PE_INST_W),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef LOADER_ABORT_EN
        .abort    (abort),
`endif
        .inst_len (inst_len),
        .run_len  (run_len),
        .inst     (host),
        .pe_rst   (pe_rst),
        .PE_inst  (PE_inst),
        .init     (init),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] obs_pack();
        return {pe_rst, init, run, busy, done, err, host.s_inst_ready};
    endfunction

    function automatic logic [6:0] exp_pack(input int c);
        return {e_prst[c], e_init[c], e_run[c], e_busy[c], e_done[c], e_err[c], e_rdy[c]};
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < MAXC; c++) begin
            e_prst[c] = 1'b0; e_init[c] = 1'b0; e_run[c] = 1'b0; e_busy[c] = 1'b0;
            e_done[c] = 1'b0; e_err[c]  = 1'b0; e_rdy[c] = 1'b0; spat[c]   = 1'b0;
        end
    endfunction

    // Valid with probability pct per cycle (always valid late on), random words.
    function automatic void fill_stim(input int pct);
        for (int c = 0; c < MAXC; c++) begin
            vpat[c] = (c >= 60) ? 1'b1 : ($urandom_range(99, 0) < pct);
            dpat[c] = PE_INST_W'($urandom);
        end
    endfunction

    // PE_inst carries the word of the latest init and holds it otherwise.
    function automatic void fill_words();
        logic [PE_INST_W-1:0] w;
        w = last_word;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0 && e_init[c]) w = dpat[c-1];
            e_word[c] = w;
        end
    endfunction

    // Timeline of an accepted start in cycle 0: pe_rst in cycle 1, host
    // accepted from cycle 2 until the n-th valid word (cycle hn), each word
    // shown one cycle after its handshake, run for r cycles from hn+2, done
    // at hn+r+2. An abort in cycle ab (1..hn+r) instead yields pe_rst+err
    // in ab+1 and nothing else after it.
    task automatic build_model(input int n, input int r, input int abort_req, input int spur_req,
                               output int hn, output int last, output int ab);
        int cnt;
        cnt = 0;
        hn  = 0;
        clear_model();
        e_prst[1] = 1'b1;
        for (int c = 2; c < 100 && cnt < n; c++) begin
            e_rdy[c] = 1'b1;
            if (vpat[c]) begin
                cnt++;
                e_init[c+1] = 1'b1;
                if (cnt == n) hn = c;
            end
        end
        for (int c = 1; c <= hn + r + 1; c++) e_busy[c] = 1'b1;
        for (int c = hn + 2; c <= hn + r + 1; c++) e_run[c] = 1'b1;
        e_done[hn+r+2] = 1'b1;
        last = hn + r + 2;
        if (abort_req == 0) ab = int'($urandom_range(hn + r, 1));
        else ab = abort_req;
        if (ab > 0) begin
            for (int c = ab + 1; c < MAXC; c++) begin
                e_prst[c] = 1'b0; e_init[c] = 1'b0; e_run[c] = 1'b0; e_busy[c] = 1'b0;
                e_done[c] = 1'b0; e_err[c]  = 1'b0; e_rdy[c] = 1'b0;
            end
            e_prst[ab+1] = 1'b1;
            e_err[ab+1]  = 1'b1;
            last = ab + 2;
        end
        if (spur_req < 0) spat[$urandom_range(hn + r + 1, 1)] = 1'b1;
        else if (spur_req > 0) spat[spur_req] = 1'b1;
        fill_words();
    endtask

    task automatic run_loop(input int last, input int n, input int r, input int ab,
                            input int rst_cyc, output int obs_done);
        bit stopped;
        stopped  = 1'b0;
        obs_done = -1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            check($sformatf("strobes@%0d", c), 32'(obs_pack()), 32'(exp_pack(c)));
            check($sformatf("PE_inst@%0d", c), 32'(PE_inst), 32'(e_word[c]));
            if (done) obs_done = c;
            if (c == rst_cyc) begin
                rst   = 1'b0;
                start = 1'b0;
                host.s_inst_valid = 1'b0;
`ifdef LOADER_ABORT_EN
                abort = 1'b0;
`endif
                #1;
                check("rst_async_strobes", 32'(obs_pack()), 32'h40);
                check("rst_async_word", 32'(PE_inst), 32'h0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("rst_release_strobes", 32'(obs_pack()), 32'h0);
                last_word = '0;
                stopped   = 1'b1;
                break;
            end
            start    = (c == 0) || spat[c];
            inst_len = (c == 0) ? CNT_W'(n) : CNT_W'($urandom);
            run_len  = (c == 0) ? CNT_W'(r) : CNT_W'($urandom);
            host.s_inst_valid = vpat[c];
            host.s_inst_data  = dpat[c];
`ifdef LOADER_ABORT_EN
            abort = (c == ab);
`endif
        end
        start = 1'b0;
        host.s_inst_valid = 1'b0;
`ifdef LOADER_ABORT_EN
        abort = 1'b0;
`endif
        if (!stopped) last_word = e_word[last];
    endtask

    task automatic run_seq(input int n, input int r, input int abort_req, input int rst_run,
                           input int spur_req, output int obs_done);
        int hn, last, ab, rc;
        build_model(n, r, abort_req, spur_req, hn, last, ab);
        rc = (rst_run > 0) ? hn + 1 + rst_run : -1;
        run_loop(last, n, r, ab, rc, obs_done);
    endtask

    // A rejected start: err in cycle 1 and nothing else.
    task automatic bad_start(input int n, input int r);
        int od;
        clear_model();
        e_err[1] = 1'b1;
        fill_words();
        run_loop(2, n, r, -1, -1, od);
    endtask

    initial begin
        int od, n, r, ab_req, sp;
        host.s_inst_valid = 1'b0;
        host.s_inst_data  = '0;

        // Held in reset: only pe_rst high.
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'(obs_pack()), 32'h40);
        check("reset_word", 32'(PE_inst), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_strobes", 32'(obs_pack()), 32'h0);

        // 4 words back-to-back, 4 run cycles: done 11 cycles after start.
        fill_stim(100);
        for (int i = 0; i < 4; i++) dpat[2+i] = PE_INST_W'(32'hA1 + i);
        run_seq(4, 4, -1, -1, 0, od);
        check("nostall_done_cycle", 32'(od), 32'd11);

        // Valid gaps before the 2nd and 3rd words: done two cycles later.
        fill_stim(100);
        vpat[3] = 1'b0;
        vpat[5] = 1'b0;
        dpat[2] = PE_INST_W'(32'hA1);
        dpat[4] = PE_INST_W'(32'hA2);
        dpat[6] = PE_INST_W'(32'hA3);
        dpat[7] = PE_INST_W'(32'hA4);
        run_seq(4, 4, -1, -1, 0, od);
        check("gap_done_cycle", 32'(od), 32'd13);

        // Illegal lengths are rejected with err.
        bad_start(0, 1);
        bad_start(17, 1);
        bad_start(3, 5);

        // Full-depth load with a start pulse in the middle of LOAD.
        fill_stim(100);
        run_seq(16, 1, -1, -1, 8, od);
        check("full_depth_done_cycle", 32'(od), 32'd20);

        // Reset on the 2nd run cycle, then a fresh sequence.
        fill_stim(100);
        run_seq(4, 4, -1, 2, 0, od);
        fill_stim(100);
        run_seq(4, 4, -1, -1, 0, od);
        check("after_reset_done_cycle", 32'(od), 32'd11);

`ifdef LOADER_ABORT_EN
        // Abort in the cycle after the 2nd word's handshake of a 5-word load.
        fill_stim(100);
        run_seq(5, 3, 4, -1, 0, od);
        check("abort_no_done", 32'(od), 32'hFFFF_FFFF);
`endif

        // Randomized mix of legal sequences, spurious starts, bad starts and aborts.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(4, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: begin n = 0; r = int'($urandom_range(31, 0)); end
                    1: begin n = int'($urandom_range(31, 17)); r = 1; end
                    2: begin n = int'($urandom_range(16, 1)); r = 0; end
                    default: begin n = int'($urandom_range(15, 1)); r = int'($urandom_range(31, n + 1)); end
                endcase
                bad_start(n, r);
            end else begin
                n = int'($urandom_range(DEPTH, 1));
                r = int'($urandom_range(n, 1));
                ab_req = -1;
`ifdef LOADER_ABORT_EN
                if ($urandom_range(2, 0) == 0) ab_req = 0;
`endif
                sp = (ab_req < 0 && $urandom_range(1, 0) == 1) ? -1 : 0;
                fill_stim(int'($urandom_range(100, 40)));
                run_seq(n, r, ab_req, -1, sp, od);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/pe_config_loader.md
Name: pe_config_loader

Overview:
- Transmit side of the PE configuration interface: streams instruction words into a PE's configuration buffer using the PE_inst/init protocol, then sequences execution with run.
- Sits between a host instruction source (valid/ready stream) and one PE or a broadcast group of PEs.
- Issues a clearing reset to the PE before every load, because the PE's init/run counters only clear on reset.

Parameters:
- PE_INST_W, 28, instruction width; equals `PE_inst.
- DEPTH, 16, PE configuration buffer depth; equals `buffer_depth.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load+run sequence; sampled only in IDLE.
- inst_len  in  CNT_W  number of instructions to load; latched on accepted start.
- run_len  in  CNT_W  number of run cycles; latched on accepted start.
- s_inst_data  in  PE_INST_W  instruction word from host.
- s_inst_valid  in  1  host data valid.
- s_inst_ready  out  1  loader accepts a word this cycle.
- pe_rst  out  1  active-high synchronous reset to the PE(s).
- PE_inst  out  PE_INST_W  instruction word to the PE.
- init  out  1  PE buffer write strobe.
- run  out  1  PE execute strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse when a start is rejected (or an abort occurs; see Optional Feature).

Behaviour:
- Reset (rst=0, async): state=IDLE. Counters=0. PE_inst=0. init=0, run=0, done=0, err=0, s_inst_ready=0. pe_rst=1 while rst is asserted, so the PE is held in reset with the loader.
- All outputs are registered except s_inst_ready, which is decoded from state.
- States: IDLE, CLR, LOAD, RUN, FIN.
- IDLE, start=1:
  - If 1 ≤ inst_len ≤ DEPTH and 1 ≤ run_len ≤ inst_len: latch both lengths, go to CLR.
  - Otherwise: pulse err for one cycle, stay in IDLE.
- start while busy: ignored, no err.
- CLR: pe_rst=1 for exactly one cycle; load counter cleared; go to LOAD.
- LOAD:
  - s_inst_ready=1.
  - Each cycle with s_inst_valid & s_inst_ready: next cycle PE_inst=s_inst_data and init=1; load counter increments.
  - Cycle without a handshake: init=0 next cycle; PE_inst holds its last value.
  - Handshake that makes the count equal inst_len: s_inst_ready drops the next cycle; go to RUN.
  - Back-to-back valid gives one instruction per cycle.
- RUN:
  - run=1 for exactly run_len consecutive cycles; init=0 throughout.
  - The first run cycle immediately follows the cycle carrying the last init; no gap cycle.
  - Run counter reaches run_len: go to FIN.
- FIN: done=1 for one cycle, run=0; go to IDLE.
- init and run are never high in the same cycle.
- pe_rst is high only in CLR, or while rst is asserted.
- Latency, start to first init: 3 cycles (start sampled → CLR → LOAD handshake → init registered), assuming valid is already high.
- Total with no stalls: start at cycle 0 → done at cycle 3+inst_len+run_len.
- Reset asserted mid-LOAD or mid-RUN: immediate return to IDLE; all strobes drop asynchronously; pe_rst asserts.

Optional Feature:
- Macro LOADER_ABORT_EN adds input port abort (1 bit).
- Defined: abort=1 in CLR, LOAD or RUN forces, on the next cycle:
  - init=0, run=0, s_inst_ready=0;
  - pe_rst=1 for one cycle;
  - err pulse for one cycle, no done;
  - state=IDLE.
- Defined: abort in IDLE or FIN has no effect.
- Not defined: no abort port; sequences always run to completion unless rst is asserted.

Test Plan:
- Reset release, then start, inst_len=4, run_len=4, valid held high with words 0xA1..0xA4 → one pe_rst pulse; init high 4 cycles carrying 0xA1..0xA4; run high 4 cycles; done at cycle 11 after start.
- Same config with s_inst_valid low on the 2nd and 3rd words' cycles → init gaps of 1 cycle each; PE_inst held; done delayed by 2 cycles.
- start with inst_len=0, then inst_len=17, then inst_len=3/run_len=5 → err pulse each time; busy stays 0; no pe_rst, init or run.
- start pulsed during LOAD of inst_len=16, run_len=1 → ignored; exactly 16 init cycles, 1 run cycle, single done.
- rst=0 asserted on the 2nd run cycle → run drops immediately; pe_rst=1; state IDLE after release; a new start behaves as a fresh sequence.
- LOADER_ABORT_EN defined, abort after 2 of 5 words → init drops the next cycle; one pe_rst pulse; err=1, done=0; busy=0.
